prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Boot-time program loader between a UART byte receiver and the CPU's instruction and data memories.
- Parses a framed byte stream and writes payload bytes into instruction memory (IM) or data memory (DM).
- Holds the pipelined CPU in reset through cpu_rst_n until a valid RUN frame arrives.
- Allows the FPGA image to be reloaded without resynthesis.

Parameters:
IM_SIZE, 1024, IM depth in bytes
DM_SIZE, 1024, DM depth in bytes
ADDR_W, 16, width of mem_addr and of the frame address/length fields
TIMEOUT_CYC, 100000, maximum idle clk cycles between bytes inside a frame

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid; a byte transfers when rx_valid && rx_ready
rx_ready  out  1  loader accepts a byte
mem_addr  out  ADDR_W  byte address of write
mem_wdata  out  8  write byte
im_we  out  1  IM byte write strobe
dm_we  out  1  DM byte write strobe
cpu_rst_n  out  1  active-low reset to CPU core
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse at end of every frame, good or bad
err  out  4  sticky {tmo, cmd, range, chk}; cleared on next SYNC
tx_data  out  8  status byte (LOADER_ECHO_EN)
tx_valid  out  1  status byte valid (LOADER_ECHO_EN)
tx_ready  in  1  status consumer ready (LOADER_ECHO_EN)

Behaviour:
- Frame format: SYNC=0xA5, CMD, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN payload bytes, CHK.
  - CHK = XOR of every byte from CMD through the last payload byte.
  - CMD values: 0x01 write IM, 0x02 write DM, 0x03 RUN. RUN ignores ADDR and requires LEN=0.
- Reset values: cpu_rst_n=0, rx_ready=1, im_we=dm_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, err=0, tx_valid=0, tx_data=0. State is IDLE.
- FSM states: IDLE -> CMD -> ADDR_H -> ADDR_L -> LEN_H -> LEN_L -> (DATA if LEN!=0) -> CHK -> (RESP if echo enabled) -> IDLE. Each transition consumes exactly one accepted byte, except RESP.
- IDLE discards every byte other than 0xA5.
- Unknown CMD:
  - sets err[2] (cmd), returns to IDLE.
  - frame_done pulses; under LOADER_ECHO_EN, goes to RESP with NAK instead.
- Accepting CMD 0x01 or 0x02 drives cpu_rst_n low in the following cycle. It stays low until a good RUN frame.
- DATA: each accepted payload byte produces a registered write one cycle later.
  - we high for exactly one cycle; mem_addr = ADDR + index; mem_wdata = byte.
  - Back-to-back bytes give back-to-back strobes. No internal buffering.
- Range: address >= IM_SIZE (or DM_SIZE) suppresses the write and sets err[1].
  - The payload is still consumed.
  - The address counter does not wrap at 2^ADDR_W; it saturates and the write stays suppressed.
- Writes are not rolled back on checksum failure; a CHK mismatch sets err[0].
- RUN: with a good CHK and LEN=0, cpu_rst_n goes high 1 cycle after the CHK byte. A bad RUN leaves cpu_rst_n unchanged.
- Timeout: counter is cleared on every accepted byte and runs in every state except IDLE and RESP. At TIMEOUT_CYC it sets err[3], pulses frame_done and returns to IDLE.
- frame_done pulses the cycle after CHK is accepted, or on abort.
- rx_ready is 1 in every state except RESP.
- Asserting rst_n mid-frame aborts immediately: all outputs go to reset values and cpu_rst_n returns to 0.

Optional Feature:
LOADER_ECHO_EN
- Defined:
  - after CHK or an abort, FSM enters RESP and drives tx_valid=1 with tx_data=0x06 (ACK, err==0) or 0x15 (NAK).
  - tx_valid and tx_data hold until tx_ready; then return to IDLE.
  - rx_ready=0 while in RESP.
- Undefined: tx_valid=0, tx_data=0, tx_ready ignored, no RESP state.

Decomposition:
- Shared SYSTEM_DEF.vh additions:
  - LDR_SYNC, LDR_CMD_WIM, LDR_CMD_WDM, LDR_CMD_RUN, LDR_ACK, LDR_NAK.
  - FSM state encodings.
  - IM/DM size defaults tied to INSTR_MEM_SIZE and DATA_MEM_SIZE.
- One sub-module: ldr_timeout, a loadable down-counter with clear/enable/expire.

Test Plan:
- Write IM, 4 bytes at 0x0000: A5 01 00 00 00 04 13 00 00 00 16 -> im_we pulses on addr 0..3 with data 13,00,00,00; err=0; cpu_rst_n stays 0.
- Same frame with CHK=0x17 -> four writes occur; err=4'b0001; frame_done pulses once; with echo, tx_data=0x15.
- RUN: A5 03 00 00 00 00 03 -> cpu_rst_n rises 1 cycle after CHK. A following A5 01 drops it again.
- Range: write DM at 0x03FF, LEN=2, DM_SIZE=1024 -> exactly one dm_we (addr 0x03FF); err[1]=1; frame completes normally.
- Timeout: send A5 02 00, then idle TIMEOUT_CYC cycles -> err=4'b1000; busy=0; a following A5 clears err.
- Stalled rx_valid with gaps < TIMEOUT_CYC between payload bytes, and rst_n pulsed mid-payload -> no spurious writes; all outputs at reset values.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants, state encoding and helpers for the boot-time program loader.
package prog_loader_pkg;

  localparam logic [7:0] LDR_SYNC    = 8'hA5;
  localparam logic [7:0] LDR_CMD_WIM = 8'h01;
  localparam logic [7:0] LDR_CMD_WDM = 8'h02;
  localparam logic [7:0] LDR_CMD_RUN = 8'h03;
  localparam logic [7:0] LDR_ACK     = 8'h06;
  localparam logic [7:0] LDR_NAK     = 8'h15;

  localparam int INSTR_MEM_SIZE = 1024;
  localparam int DATA_MEM_SIZE  = 1024;

  // Bit positions inside the sticky err vector {tmo, cmd, range, chk}
  localparam int ERR_TMO   = 3;
  localparam int ERR_CMD   = 2;
  localparam int ERR_RANGE = 1;
  localparam int ERR_CHK   = 0;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_ADDR_H = 4'd2,
    ST_ADDR_L = 4'd3,
    ST_LEN_H  = 4'd4,
    ST_LEN_L  = 4'd5,
    ST_DATA   = 4'd6,
    ST_CHK    = 4'd7,
    ST_RESP   = 4'd8
  } ldr_state_e;

  function automatic logic is_known_cmd(input logic [7:0] c);
    return (c == LDR_CMD_WIM) || (c == LDR_CMD_WDM) || (c == LDR_CMD_RUN);
  endfunction

endpackage

// File: rtl/ldr_timeout.sv
// Inter-byte idle watchdog: loadable down-counter with clear, enable and expire.
module ldr_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  // Held at LOAD while disabled, so the full budget restarts on every frame byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clr || !en) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = en && !clr && (cnt == CW'(1));

endmodule

// File: rtl/prog_loader.sv
// Framed UART byte-stream loader into IM/DM; holds the CPU in reset until a good RUN frame.
// Optional status echo (ACK/NAK on tx_*) is built when LOADER_ECHO_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IM_SIZE     = INSTR_MEM_SIZE,
  parameter int DM_SIZE     = DATA_MEM_SIZE,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              im_we,
  output logic              dm_we,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              frame_done,
  output logic [3:0]        err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam logic [ADDR_W:0] IM_LIM = (ADDR_W+1)'(IM_SIZE);
  localparam logic [ADDR_W:0] DM_LIM = (ADDR_W+1)'(DM_SIZE);

  ldr_state_e        state;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] addr_cnt;
  logic              addr_sat;
  logic [ADDR_W-1:0] len_cnt;
  logic              len_nz;
  logic [7:0]        chk_acc;

  logic              acc;
  logic              tmo;
  logic              tmo_en;
  logic              is_wr;
  logic              in_range;
  logic              frame_end;
  logic [3:0]        err_set;
  logic [3:0]        err_next;
  logic [ADDR_W-1:0] len_shift;

  // Handshake: a byte transfers on a clock edge where rx_valid && rx_ready.
  assign rx_ready = (state != ST_RESP);
  assign busy     = (state != ST_IDLE);
  assign tmo_en   = (state != ST_IDLE) && (state != ST_RESP);

  ldr_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc),
    .en     (tmo_en),
    .expire (tmo)
  );

  always_comb begin
    acc       = rx_valid && rx_ready;
    is_wr     = (cmd == LDR_CMD_WIM) || (cmd == LDR_CMD_WDM);
    in_range  = !addr_sat &&
                ({1'b0, addr_cnt} < ((cmd == LDR_CMD_WIM) ? IM_LIM : DM_LIM));
    len_shift = {len_cnt[ADDR_W-9:0], rx_data};
    err_set   = '0;
    frame_end = tmo;
    if (tmo) err_set[ERR_TMO] = 1'b1;
    case (state)
      ST_CMD: begin
        if (acc && !is_known_cmd(rx_data)) begin
          err_set[ERR_CMD] = 1'b1;
          frame_end        = 1'b1;
        end
      end
      ST_DATA: begin
        if (acc && is_wr && !in_range) err_set[ERR_RANGE] = 1'b1;
      end
      ST_CHK: begin
        if (acc) begin
          frame_end = 1'b1;
          if (rx_data != chk_acc) err_set[ERR_CHK] = 1'b1;
          // RUN carrying a payload is malformed and must not release the CPU
          if ((cmd == LDR_CMD_RUN) && len_nz) err_set[ERR_CMD] = 1'b1;
        end
      end
      default: ;
    endcase
    err_next = err | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd        <= '0;
      addr_cnt   <= '0;
      addr_sat   <= 1'b0;
      len_cnt    <= '0;
      len_nz     <= 1'b0;
      chk_acc    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      im_we      <= 1'b0;
      dm_we      <= 1'b0;
      cpu_rst_n  <= 1'b0;
      frame_done <= 1'b0;
      err        <= '0;
`ifdef LOADER_ECHO_EN
      tx_valid   <= 1'b0;
      tx_data    <= '0;
`endif
    end else begin
      im_we      <= 1'b0;
      dm_we      <= 1'b0;
      frame_done <= 1'b0;
      err        <= err_next;
      case (state)
        ST_IDLE: begin
          if (acc && (rx_data == LDR_SYNC)) begin
            state   <= ST_CMD;
            err     <= '0;
            chk_acc <= '0;
          end
        end
        ST_CMD: begin
          if (acc) begin
            cmd     <= rx_data;
            chk_acc <= rx_data;
            state   <= ST_ADDR_H;
            if ((rx_data == LDR_CMD_WIM) || (rx_data == LDR_CMD_WDM)) cpu_rst_n <= 1'b0;
          end
        end
        ST_ADDR_H, ST_ADDR_L: begin
          if (acc) begin
            addr_cnt <= {addr_cnt[ADDR_W-9:0], rx_data};
            addr_sat <= 1'b0;
            chk_acc  <= chk_acc ^ rx_data;
            state    <= (state == ST_ADDR_H) ? ST_ADDR_L : ST_LEN_H;
          end
        end
        ST_LEN_H: begin
          if (acc) begin
            len_cnt <= len_shift;
            chk_acc <= chk_acc ^ rx_data;
            state   <= ST_LEN_L;
          end
        end
        ST_LEN_L: begin
          if (acc) begin
            len_cnt <= len_shift;
            len_nz  <= (len_shift != '0);
            chk_acc <= chk_acc ^ rx_data;
            state   <= (len_shift != '0) ? ST_DATA : ST_CHK;
          end
        end
        ST_DATA: begin
          if (acc) begin
            chk_acc <= chk_acc ^ rx_data;
            if (is_wr) begin
              mem_addr  <= addr_cnt;
              mem_wdata <= rx_data;
              if (in_range) begin
                im_we <= (cmd == LDR_CMD_WIM);
                dm_we <= (cmd == LDR_CMD_WDM);
              end
            end
            // Saturate rather than wrap so an overrun never lands on low memory
            if (addr_cnt == '1) addr_sat <= 1'b1;
            else                addr_cnt <= addr_cnt + ADDR_W'(1);
            len_cnt <= len_cnt - ADDR_W'(1);
            if (len_cnt == ADDR_W'(1)) state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (acc && (rx_data == chk_acc) && (cmd == LDR_CMD_RUN) && !len_nz)
            cpu_rst_n <= 1'b1;
        end
        ST_RESP: begin
`ifdef LOADER_ECHO_EN
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            state    <= ST_IDLE;
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
      if (frame_end) begin
        frame_done <= 1'b1;
`ifdef LOADER_ECHO_EN
        state    <= ST_RESP;
        tx_valid <= 1'b1;
        tx_data  <= (err_next == 4'b0000) ? LDR_ACK : LDR_NAK;
`else
        state    <= ST_IDLE;
`endif
      end
    end
  end

`ifndef LOADER_ECHO_EN
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign tx_valid = 1'b0;
  assign tx_data  = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame writes, checksum, RUN, range, timeout, stall and reset abort.
module tb_prog_loader;

  localparam int TMO    = 64;
  localparam int ADDR_W = 16;
  localparam int W      = 2 + ADDR_W + 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              im_we, dm_we, cpu_rst_n, busy, frame_done;
  logic [3:0]        err;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;

  int n_vec  = 0;
  int n_miss = 0;
  int fd_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [7:0]   seq[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  prog_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .im_we(im_we), .dm_we(dm_we),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .frame_done(frame_done), .err(err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // write and frame_done monitor
  always @(negedge clk) begin
    if (im_we || dm_we) obs_q.push_back({dm_we, im_we, mem_addr, mem_wdata});
    if (frame_done) fd_cnt++;
  end

  // driver: returns #1 after the edge that transferred the byte
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) begin
      n_vec++; n_miss++;
      $display("FAIL rx_ready_wait: got rx_ready=0 for %0d cycles expected 1", n);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_vec++;
    if ({cpu_rst_n, rx_ready, im_we, dm_we, busy, frame_done, tx_valid} !== 7'b0100000) begin
      n_miss++;
      $display("FAIL reset_ctrl: got %b expected 0100000",
               {cpu_rst_n, rx_ready, im_we, dm_we, busy, frame_done, tx_valid});
    end
    rst_n = 1'b1;
    idle(2);
    n_vec++;
    if ({mem_addr, mem_wdata, tx_data} !== 32'h0) begin
      n_miss++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, tx_data});
    end
    n_vec++;
    if (err !== 4'b0000 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_err: got err=%b busy=%b expected 0000 0", err, busy);
    end
  endtask

  task automatic test_write_im();
    logic [7:0] pl[4];
    int base = obs_q.size();
    int fd0  = fd_cnt;
    pl = '{8'h13, 8'h00, 8'h00, 8'h00};
    seq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
    send_seq();
    for (int i = 0; i < 4; i++) begin
      send_byte(pl[i]);
      n_vec++;
      if ({im_we, dm_we, mem_addr, mem_wdata} !== {2'b10, 16'(i), pl[i]}) begin
        n_miss++;
        $display("FAIL im_write_%0d: got we=%b%b addr=%h data=%h expected 10 %h %h",
                 i, im_we, dm_we, mem_addr, mem_wdata, 16'(i), pl[i]);
      end
    end
    send_byte(8'h16);
    n_vec++;
    if ({frame_done, err, cpu_rst_n} !== 6'b1_0000_0) begin
      n_miss++;
      $display("FAIL im_frame_end: got done=%b err=%b cpu=%b expected 1 0000 0",
               frame_done, err, cpu_rst_n);
    end
    idle(2);
    n_vec++;
    if (obs_q.size() - base !== 4 || fd_cnt - fd0 !== 1 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL im_counts: got writes=%0d done=%0d busy=%b expected 4 1 0",
               obs_q.size() - base, fd_cnt - fd0, busy);
    end
  endtask

  task automatic test_bad_chk();
    int base = obs_q.size();
    int fd0  = fd_cnt;
    exp_q = '{{2'b01, 16'h0000, 8'h13}, {2'b01, 16'h0001, 8'h00},
              {2'b01, 16'h0002, 8'h00}, {2'b01, 16'h0003, 8'h00}};
    seq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h00, 8'h00, 8'h00, 8'h17};
    send_seq();
    n_vec++;
    if (err !== 4'b0001) begin
      n_miss++;
      $display("FAIL chk_err: got %b expected 0001", err);
    end
`ifdef LOADER_ECHO_EN
    n_vec++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h15}) begin
      n_miss++;
      $display("FAIL chk_nak: got %b %h expected 1 15", tx_valid, tx_data);
    end
`endif
    idle(3);
    n_vec++;
    if (fd_cnt - fd0 !== 1) begin
      n_miss++;
      $display("FAIL chk_done_count: got %0d expected 1", fd_cnt - fd0);
    end
    n_vec++;
    if (obs_q.size() - base !== exp_q.size()) begin
      n_miss++;
      $display("FAIL chk_writes: got %0d expected %0d", obs_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_vec++;
        if (obs_q[base+i] !== exp_q[i]) begin
          n_miss++;
          $display("FAIL chk_write_%0d: got %h expected %h", i, obs_q[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_run();
    int base = obs_q.size();
    seq = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    send_seq();
    n_vec++;
    if (cpu_rst_n !== 1'b0) begin
      n_miss++;
      $display("FAIL run_before_chk: got %b expected 0", cpu_rst_n);
    end
    send_byte(8'h03);
    n_vec++;
    if ({cpu_rst_n, frame_done, err} !== 6'b11_0000) begin
      n_miss++;
      $display("FAIL run_release: got cpu=%b done=%b err=%b expected 1 1 0000",
               cpu_rst_n, frame_done, err);
    end
    idle(2);
    seq = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
    send_seq();
    n_vec++;
    if ({cpu_rst_n, err} !== 5'b1_0001) begin
      n_miss++;
      $display("FAIL run_bad: got cpu=%b err=%b expected 1 0001", cpu_rst_n, err);
    end
    idle(2);
    seq = '{8'hA5, 8'h01};
    send_seq();
    n_vec++;
    if ({cpu_rst_n, busy} !== 2'b01) begin
      n_miss++;
      $display("FAIL run_reassert: got cpu=%b busy=%b expected 0 1", cpu_rst_n, busy);
    end
    seq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    send_seq();
    idle(2);
    n_vec++;
    if (err !== 4'b0000 || obs_q.size() !== base || cpu_rst_n !== 1'b0) begin
      n_miss++;
      $display("FAIL run_empty_write: got err=%b writes=%0d cpu=%b expected 0000 0 0",
               err, obs_q.size() - base, cpu_rst_n);
    end
  endtask

  task automatic test_range();
    int base = obs_q.size();
    int fd0  = fd_cnt;
    exp_q = '{{2'b10, 16'h03FF, 8'hAA}};
    seq = '{8'hA5, 8'h02, 8'h03, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hED};
    send_seq();
    idle(2);
    n_vec++;
    if (err !== 4'b0010 || fd_cnt - fd0 !== 1) begin
      n_miss++;
      $display("FAIL range_err: got err=%b done=%0d expected 0010 1", err, fd_cnt - fd0);
    end
    n_vec++;
    if (obs_q.size() - base !== exp_q.size()) begin
      n_miss++;
      $display("FAIL range_writes: got %0d expected %0d", obs_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_vec++;
        if (obs_q[base+i] !== exp_q[i]) begin
          n_miss++;
          $display("FAIL range_write_%0d: got %h expected %h", i, obs_q[base+i], exp_q[i]);
        end
      end
    end
    base = obs_q.size();
    seq = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h30};
    send_seq();
    idle(2);
    n_vec++;
    if (err !== 4'b0010 || obs_q.size() !== base) begin
      n_miss++;
      $display("FAIL range_saturate: got err=%b writes=%0d expected 0010 0",
               err, obs_q.size() - base);
    end
  endtask

  task automatic test_bad_cmd();
    seq = '{8'hA5, 8'h07};
    send_seq();
    n_vec++;
    if ({frame_done, err} !== 5'b1_0100) begin
      n_miss++;
      $display("FAIL cmd_unknown: got done=%b err=%b expected 1 0100", frame_done, err);
    end
    idle(2);
    seq = '{8'h00, 8'h07, 8'h55};
    send_seq();
    n_vec++;
    if (busy !== 1'b0 || err !== 4'b0100) begin
      n_miss++;
      $display("FAIL idle_discard: got busy=%b err=%b expected 0 0100", busy, err);
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    seq = '{8'hA5, 8'h02, 8'h00};
    send_seq();
    while (k < TMO + 20) begin
      @(posedge clk); #1;
      k++;
      if (frame_done) break;
    end
    n_vec++;
    if (k !== TMO || err !== 4'b1000) begin
      n_miss++;
      $display("FAIL timeout: got cycles=%0d err=%b expected %0d 1000", k, err, TMO);
    end
    idle(2);
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++;
      $display("FAIL timeout_busy: got %b expected 0", busy);
    end
    send_byte(8'hA5);
    n_vec++;
    if (err !== 4'b0000) begin
      n_miss++;
      $display("FAIL timeout_clear: got %b expected 0000", err);
    end
    seq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    send_seq();
    n_vec++;
    if (cpu_rst_n !== 1'b1) begin
      n_miss++;
      $display("FAIL timeout_then_run: got %b expected 1", cpu_rst_n);
    end
    idle(2);
  endtask

  task automatic test_stall_reset();
    int base = obs_q.size();
    exp_q = '{{2'b01, 16'h0010, 8'h5A}, {2'b01, 16'h0011, 8'h6B}};
    seq = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h04};
    send_seq();
    send_byte(8'h5A);
    idle(20);
    send_byte(8'h6B);
    idle(40);
    n_vec++;
    if (err !== 4'b0000 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL stall_no_tmo: got err=%b busy=%b expected 0000 1", err, busy);
    end
    n_vec++;
    if (obs_q.size() - base !== exp_q.size()) begin
      n_miss++;
      $display("FAIL stall_writes: got %0d expected %0d", obs_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_vec++;
        if (obs_q[base+i] !== exp_q[i]) begin
          n_miss++;
          $display("FAIL stall_write_%0d: got %h expected %h", i, obs_q[base+i], exp_q[i]);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({cpu_rst_n, rx_ready, im_we, dm_we, busy, frame_done, tx_valid,
         err, tx_data, mem_addr, mem_wdata} !== {7'b0100000, 36'h0}) begin
      n_miss++;
      $display("FAIL abort_reset: got %h expected %h",
               {cpu_rst_n, rx_ready, im_we, dm_we, busy, frame_done, tx_valid,
                err, tx_data, mem_addr, mem_wdata}, {7'b0100000, 36'h0});
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    seq = '{8'h7C, 8'h8D};
    send_seq();
    idle(2);
    n_vec++;
    if (obs_q.size() - base !== 2 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL abort_no_spurious: got writes=%0d busy=%b expected 2 0",
               obs_q.size() - base, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_im();
    test_bad_chk();
    test_run();
    test_range();
    test_bad_cmd();
    test_timeout();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
